mem_arbiter: RTL and testbench

//   Shares the single-port synchronous ram between two requesters:
//   - the instruction-fetch path (program_counter/control), port I
//   - the load/store data path, port D

---
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: data path has
// priority, fetch is guaranteed a slot after MAX_D_BURST consecutive data wins.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 30,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam logic [3:0] MAX_B = 4'(MAX_D_BURST);

  owner_t      r_owner;
  owner_t      w_owner_nxt;
  logic [3:0]  r_streak;
  logic [3:0]  w_streak_nxt;
  logic        w_i_win;
  logic        w_d_win;

  // Fetch wins when alone or once data has used up its burst allowance.
  assign w_i_win = i_req & (~d_req | (r_streak >= MAX_B));
  assign w_d_win = d_req & ~w_i_win;

  // Grants are held low while reset is asserted so no access reaches the RAM.
  assign i_gnt = rst_n & w_i_win;
  assign d_gnt = rst_n & w_d_win;

  always_comb begin
    mem_addr = i_addr;
    mem_din  = '0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    if (d_gnt) begin
      mem_addr = d_addr;
      mem_din  = d_wdata;
      mem_re   = ~d_we;
      mem_we   = d_we;
    end else if (i_gnt) begin
      mem_re   = 1'b1;
    end
  end

  always_comb begin
    w_owner_nxt  = OWN_NONE;
    w_streak_nxt = r_streak;
    if (i_gnt) begin
      w_owner_nxt = OWN_I;
    end else if (d_gnt && !d_we) begin
      w_owner_nxt = OWN_D;
    end
    if (!i_req || i_gnt) begin
      w_streak_nxt = 4'd0;
    end else if (d_gnt && (r_streak < MAX_B)) begin
      w_streak_nxt = r_streak + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner  <= OWN_NONE;
      r_streak <= 4'd0;
    end else begin
      r_owner  <= w_owner_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  assign i_rvalid = (r_owner == OWN_I);
  assign d_rvalid = (r_owner == OWN_D);
  assign i_rdata  = mem_dout;
  assign d_rdata  = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level
// model of the grant rules, the streak allowance and the RAM contents.
module tb_mem_arbiter;
  localparam int AW  = 30;
  localparam int DW  = 32;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_gnt, d_gnt, i_rvalid, d_rvalid, mem_re, mem_we;
  logic [DW-1:0] i_rdata, d_rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_D_BURST(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_re(mem_re), .mem_we(mem_we),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM, 1-cycle registered read; preloaded with A000_0000 + index.
  logic [DW-1:0] ram [64];
  bit            ram_loaded;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int k = 0; k < 64; k++) ram[k] <= 32'hA000_0000 + k;
      ram_loaded <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr[5:0]] <= mem_din;
      if (mem_re) mem_dout <= ram[mem_addr[5:0]];
    end
  end

  // Reference model state: 0 = none, 1 = fetch, 2 = data
  logic [DW-1:0] model_mem [64];
  int            m_streak;
  int            m_pend;
  logic [DW-1:0] m_pend_data;
  int            g_last;
  int            g_act;
  int            n_pass = 0;
  int            n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  function automatic int model_grant();
    if (!rst_n) return 0;
    if (d_req && i_req) return (m_streak >= MAX) ? 1 : 2;
    if (d_req) return 2;
    if (i_req) return 1;
    return 0;
  endfunction

  function automatic void model_update(input int eg);
    if (!rst_n) begin
      m_pend = 0;
      m_streak = 0;
      return;
    end
    m_pend = 0;
    if (eg == 1) begin
      m_pend = 1;
      m_pend_data = model_mem[i_addr[5:0]];
    end else if (eg == 2) begin
      if (d_we) model_mem[d_addr[5:0]] = d_wdata;
      else begin
        m_pend = 2;
        m_pend_data = model_mem[d_addr[5:0]];
      end
    end
    if (!i_req || eg == 1) m_streak = 0;
    else if (eg == 2 && m_streak < MAX) m_streak++;
  endfunction

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic step();
    int eg;
    #4;
    eg = model_grant();
    g_last = eg;
    g_act = d_gnt ? 2 : (i_gnt ? 1 : 0);
    chk("i_gnt", i_gnt, eg == 1);
    chk("d_gnt", d_gnt, eg == 2);
    chk("mem_re", mem_re, (eg == 1) || (eg == 2 && !d_we));
    chk("mem_we", mem_we, eg == 2 && d_we);
    chk("mem_addr", mem_addr, (eg == 2) ? d_addr : i_addr);
    chk("mem_din", mem_din, (eg == 2) ? d_wdata : 32'h0);
    chk("i_rvalid", i_rvalid, m_pend == 1);
    chk("d_rvalid", d_rvalid, m_pend == 2);
    if (m_pend == 1) chk("i_rdata", i_rdata, m_pend_data);
    if (m_pend == 2) chk("d_rdata", d_rdata, m_pend_data);
    @(posedge clk);
    model_update(eg);
    #1;
  endtask

  task automatic drive(input logic ir, input int ia, input logic dr, input logic dwe,
                       input int da, input logic [31:0] wd);
    i_req = ir; i_addr = AW'(ia);
    d_req = dr; d_we = dwe; d_addr = AW'(da); d_wdata = wd;
  endtask

  int  seq_a [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
  bit  i_wait, d_wait;

  initial begin
    for (int k = 0; k < 64; k++) model_mem[k] = 32'hA000_0000 + k;
    m_streak = 0; m_pend = 0; m_pend_data = '0; g_last = 0; g_act = 0;
    rst_n = 1'b0;
    drive(1, 1, 1, 1, 2, 32'h1234_5678);
    @(posedge clk); #1;
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // 1: fetch only
    for (int k = 0; k < 4; k++) begin
      drive(1, k, 0, 0, 0, 0);
      step();
      chk("t1_grant", g_act, 1);
      chk("t1_i_rvalid", i_rvalid, 1);
      chk("t1_i_rdata", i_rdata, 32'hA000_0000 + k);
    end
    drive(0, 0, 0, 0, 0, 0);
    step();

    // 2: write then read back
    drive(0, 0, 1, 1, 5, 32'hDEAD_BEEF);
    step();
    chk("t2_wr_no_rvalid", d_rvalid, 0);
    drive(0, 0, 1, 0, 5, 0);
    step();
    chk("t2_d_rvalid", d_rvalid, 1);
    chk("t2_d_rdata", d_rdata, 32'hDEAD_BEEF);
    drive(0, 0, 0, 0, 0, 0);
    step();

    // 3: sustained conflict
    drive(1, 10, 1, 0, 20, 0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t3_seq", g_act, seq_a[k]);
    end
    drive(0, 0, 0, 0, 0, 0);
    step();

    // 4: reset right after a fetch grant
    drive(1, 7, 0, 0, 0, 0);
    step();
    rst_n = 1'b0;
    m_pend = 0; m_streak = 0;
    drive(1, 7, 1, 1, 8, 32'h5555_AAAA);
    #1;
    chk("t4_i_rvalid_killed", i_rvalid, 0);
    step();
    step();
    rst_n = 1'b1;
    d_we = 1'b0;
    step();
    chk("t4_post_rst_d", g_act, 2);
    drive(0, 0, 0, 0, 0, 0);
    step();

    // 5: owner change on consecutive cycles
    drive(1, 9, 0, 0, 0, 0);
    step();
    chk("t5_i_rvalid", i_rvalid, 1);
    chk("t5_d_rvalid0", d_rvalid, 0);
    chk("t5_i_rdata", i_rdata, 32'hA000_0009);
    drive(0, 0, 1, 0, 11, 0);
    step();
    chk("t5_d_rvalid", d_rvalid, 1);
    chk("t5_i_rvalid0", i_rvalid, 0);
    chk("t5_d_rdata", d_rdata, 32'hA000_000B);
    drive(0, 0, 0, 0, 0, 0);
    step();

    // 6: fetch withdrawal clears the streak
    drive(1, 3, 1, 0, 4, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_pre", g_act, 2);
    end
    i_req = 1'b0;
    step();
    chk("t6_gap", g_act, 2);
    i_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6_d", g_act, 2);
    end
    step();
    chk("t6_i", g_act, 1);
    drive(0, 0, 0, 0, 0, 0);
    step();

    // Randomized traffic obeying the hold-until-grant handshake
    i_wait = 0; d_wait = 0;
    for (int c = 0; c < 400; c++) begin
      if (!i_wait) begin
        i_req = ($urandom_range(3) != 0);
        i_addr = AW'($urandom_range(63));
      end else if ($urandom_range(15) == 0) begin
        i_req = 1'b0;
      end
      if (!d_wait) begin
        d_req = ($urandom_range(3) != 0);
        d_we = $urandom_range(1) == 1;
        d_addr = AW'($urandom_range(63));
        d_wdata = $urandom;
      end else if ($urandom_range(15) == 0) begin
        d_req = 1'b0;
      end
      step();
      i_wait = i_req && (g_last != 1);
      d_wait = d_req && (g_last != 2);
    end
    drive(0, 0, 0, 0, 0, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
